// File: rtl/event_sync_pkg.sv
// Shared constants and elaboration helpers for the multi-channel event synchronizer.
package event_sync_pkg;
  localparam int MIN_SYNC_STAGES = 2;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_max(input int cw);
    return (1 << cw) - 1;
  endfunction

  function automatic int sync_depth(input int n);
    return (n < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : n;
  endfunction
endpackage

// File: rtl/event_sync_chan.sv
// One channel: request synchronizer, ack return, registered edge detect, saturating pending counter.
// Overflow flag logic exists only when EVENT_SYNC_OVF_EN is defined.
module event_sync_chan
  import event_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic          i_rise_en,
  input  logic          i_dec,
  output logic          o_ack,
  output logic [CW-1:0] o_cnt,
  output logic          o_ovf
);
  localparam int NSTG = sync_depth(SYNC_STAGES);

  logic [NSTG-1:0] r_sync;
  logic            r_s_d;
  logic            r_rise;
  logic            r_ack;
  logic [CW-1:0]   r_cnt;
  logic            w_s;
  logic            w_full;
  logic            w_inc;

  assign w_s    = r_sync[NSTG-1];
  assign w_full = (r_cnt == CW'(cnt_max(CW)));
  assign w_inc  = r_rise && !w_full;

  // Rise is registered so the count lands one edge after the edge detector sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_ack  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[NSTG-2:0], i_req};
      r_s_d  <= w_s;
      r_rise <= w_s && !r_s_d && i_rise_en;
      r_ack  <= w_s;
      case ({w_inc, i_dec})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_ack = r_ack;
  assign o_cnt = r_cnt;

`ifdef EVENT_SYNC_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (r_rise && w_full) begin
      r_ovf <= 1'b1;
    end
  end
  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif
endmodule

// File: rtl/event_sync_mc.sv
// Multi-channel event synchronizer: per-channel sync/count, round-robin drain to one valid/ready port.
// Sticky overflow flags are built only when EVENT_SYNC_OVF_EN is defined.
module event_sync_mc
  import event_sync_pkg::*;
#(
  parameter int NCHAN       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCHAN-1:0]       req_in,
  output logic [NCHAN-1:0]       ack_out,
  output logic                   out_valid,
  output logic [chw(NCHAN)-1:0]  out_chan,
  input  logic                   out_ready,
  output logic [NCHAN-1:0]       ovf
);
  localparam int CHW    = chw(NCHAN);
  localparam int SETTLE = sync_depth(SYNC_STAGES) + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  logic [SW-1:0]  r_settle;
  logic [CHW-1:0] r_last;
  logic           w_settled;
  logic           w_accept;
  logic [NCHAN-1:0] w_dec;
  logic [NCHAN-1:0] w_pend;
  logic [CW-1:0]  w_cnt [NCHAN];
  logic           w_found;
  logic [CHW-1:0] w_win;
  int             w_best;

  assign w_settled = (r_settle == SW'(SETTLE));
  assign w_accept  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= '0;
    end else if (!w_settled) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign w_dec[c] = w_accept && (out_chan == CHW'(c));
    // The presented event is already spoken for, so it needs a second count to be pending.
    assign w_pend[c] = (out_valid && out_chan == CHW'(c)) ? (w_cnt[c] > CW'(1))
                                                          : (w_cnt[c] != '0);
    event_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CW         (CW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .i_req    (req_in[c]),
      .i_rise_en(w_settled),
      .i_dec    (w_dec[c]),
      .o_ack    (ack_out[c]),
      .o_cnt    (w_cnt[c]),
      .o_ovf    (ovf[c])
    );
  end

  // Winner is the pending channel at the smallest distance past the last grant.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_best  = NCHAN;
    for (int c = 0; c < NCHAN; c++) begin
      int d;
      d = (c - int'(r_last) - 1 + 2 * NCHAN) % NCHAN;
      if (w_pend[c] && d < w_best) begin
        w_best  = d;
        w_found = 1'b1;
        w_win   = CHW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      r_last    <= CHW'(NCHAN - 1);
    end else if (!out_valid || out_ready) begin
      out_valid <= w_found;
      if (w_found) begin
        out_chan <= w_win;
        r_last   <= w_win;
      end
    end
  end
endmodule
